chnl_smpl_packer: RTL and testbench

//  Parametrised, single-clock successor to the dual-clock channel sampler.

---
 rtl/chnl_smpl_pkg.sv | 8 +
 rtl/chnl_sync.sv | 19 +
 rtl/chnl_smpl_packer.sv | 104 ++++++++++
 tb/tb_chnl_smpl_packer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/chnl_smpl_pkg.sv
// chnl_smpl_pkg: shared widths, the {H,L} pair type and the slot offset helper for the sample packer
package chnl_smpl_pkg;
  localparam int SMPL_PAIR_W = 2;
  typedef logic [SMPL_PAIR_W-1:0] ch_pair_t;
  function automatic int slot_lsb(input int slot, input int num_ch);
    return SMPL_PAIR_W * num_ch * slot;
  endfunction
endpackage

// File: rtl/chnl_sync.sv
// chnl_sync: STAGES-deep, WIDTH-wide flop synchroniser, async active-low reset
//   clk, rst_n : clock and async active-low reset
//   d          : asynchronous input bits
//   q          : d after STAGES clk edges
module chnl_sync #(
  parameter int WIDTH  = 2,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES*WIDTH-1:0] ff;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff <= '0;
    else ff <= {ff[(STAGES-1)*WIDTH-1:0], d};
  assign q = ff[STAGES*WIDTH-1 -: WIDTH];
endmodule

// File: rtl/chnl_smpl_packer.sv
// chnl_smpl_packer: synchronise NUM_CH H/L comparator pairs, pack SMPLS_PER_WORD samples per valid/ready word
//   clk, rst_n        : clock, async active-low reset
//   smpl_en, clr      : sample strobe, sync clear of the partial word (clr wins over smpl_en)
//   CH_H, CH_L        : raw asynchronous comparator inputs
//   smpl, smpl_vld    : packed word (slot 0 = oldest in LSBs) and its valid
//   smpl_rdy          : consumer accept
//   ovfl, ovfl_clr    : sticky dropped-word flag and its clear (set wins)
//   H_rise/H_fall/L_rise/L_fall : per-channel edge pulses, only with CHNL_EDGE_DET_EN defined
module chnl_smpl_packer
  import chnl_smpl_pkg::*;
#(
  parameter int NUM_CH         = 1,
  parameter int SYNC_STAGES    = 2,
  parameter int SMPLS_PER_WORD = 4,
  localparam int DATA_W        = 2 * NUM_CH * SMPLS_PER_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              smpl_en,
  input  logic              clr,
  input  logic [NUM_CH-1:0] CH_H,
  input  logic [NUM_CH-1:0] CH_L,
  output logic [DATA_W-1:0] smpl,
  output logic              smpl_vld,
  input  logic              smpl_rdy,
  output logic              ovfl,
  input  logic              ovfl_clr
`ifdef CHNL_EDGE_DET_EN
  ,
  output logic [NUM_CH-1:0] H_rise,
  output logic [NUM_CH-1:0] H_fall,
  output logic [NUM_CH-1:0] L_rise,
  output logic [NUM_CH-1:0] L_fall
`endif
);
  localparam int SW = SMPL_PAIR_W * NUM_CH;
  localparam int CW = $clog2(SMPLS_PER_WORD);
  logic [2*NUM_CH-1:0] sync;
  logic [NUM_CH-1:0]   sync_h, sync_l;
  logic [SW-1:0]       slot_new;
  logic [DATA_W-1:0]   sr, sr_next;
  logic [CW-1:0]       slot_cnt;
  logic                cap, last, done, load, drop;
  chnl_sync #(.WIDTH(2*NUM_CH), .STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst_n(rst_n),
    .d({CH_H, CH_L}),
    .q(sync)
  );
  assign sync_h = sync[2*NUM_CH-1:NUM_CH];
  assign sync_l = sync[NUM_CH-1:0];
  always_comb begin
    slot_new = '0;
    for (int c = 0; c < NUM_CH; c++)
      slot_new[SMPL_PAIR_W*c +: SMPL_PAIR_W] = ch_pair_t'({sync_h[c], sync_l[c]});
  end
  // newest sample enters at the MSBs, so after a full word slot 0 holds the oldest
  assign sr_next = {slot_new, sr[DATA_W-1:SW]};
  assign cap  = smpl_en && !clr;
  assign last = slot_cnt == CW'(SMPLS_PER_WORD - 1);
  assign done = cap && last;
  assign load = done && (!smpl_vld || smpl_rdy);
  assign drop = done && smpl_vld && !smpl_rdy;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      slot_cnt <= '0;
      sr       <= '0;
      smpl     <= '0;
      smpl_vld <= 1'b0;
      ovfl     <= 1'b0;
    end else begin
      if (clr) begin
        slot_cnt <= '0;
        sr       <= '0;
      end else if (smpl_en) begin
        slot_cnt <= last ? '0 : slot_cnt + 1'b1;
        sr       <= sr_next;
      end
      if (load) smpl <= sr_next;
      smpl_vld <= load || (smpl_vld && !smpl_rdy);
      ovfl     <= drop || (ovfl && !ovfl_clr);
    end
`ifdef CHNL_EDGE_DET_EN
  logic [2*NUM_CH-1:0] prev;
  logic [NUM_CH-1:0]   prev_h, prev_l;
  assign prev_h = prev[2*NUM_CH-1:NUM_CH];
  assign prev_l = prev[NUM_CH-1:0];
  // prev survives clr so edges are judged across a cleared word boundary
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prev   <= '0;
      H_rise <= '0;
      H_fall <= '0;
      L_rise <= '0;
      L_fall <= '0;
    end else begin
      H_rise <= cap ? sync_h & ~prev_h : '0;
      H_fall <= cap ? ~sync_h & prev_h : '0;
      L_rise <= cap ? sync_l & ~prev_l : '0;
      L_fall <= cap ? ~sync_l & prev_l : '0;
      if (cap) prev <= sync;
    end
`endif
endmodule

// File: tb/tb_chnl_smpl_packer.sv
// tb_chnl_smpl_packer: directed self-checking bench for chnl_smpl_packer (default and 3ch/8spw/3stage builds)
module tb_chnl_smpl_packer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       smpl_en = 1'b0, clr = 1'b0, smpl_rdy = 1'b1, ovfl_clr = 1'b0;
  logic [0:0] ch_h = '0, ch_l = '0;
  logic [7:0] smpl;
  logic       smpl_vld, ovfl;
  logic       en5 = 1'b0, clr5 = 1'b0, rdy5 = 1'b1, oclr5 = 1'b0;
  logic [2:0] ch_h5 = '0, ch_l5 = '0;
  logic [47:0] smpl5;
  logic       vld5, ovfl5;
  int         n_chk = 0, n_fail = 0;
`ifdef CHNL_EDGE_DET_EN
  logic [0:0] h_rise, h_fall, l_rise, l_fall;
  logic [2:0] h_rise5, h_fall5, l_rise5, l_fall5;
`endif
  always #5 clk = ~clk;
  chnl_smpl_packer dut (
    .clk(clk), .rst_n(rst_n), .smpl_en(smpl_en), .clr(clr), .CH_H(ch_h), .CH_L(ch_l),
    .smpl(smpl), .smpl_vld(smpl_vld), .smpl_rdy(smpl_rdy), .ovfl(ovfl), .ovfl_clr(ovfl_clr)
`ifdef CHNL_EDGE_DET_EN
    , .H_rise(h_rise), .H_fall(h_fall), .L_rise(l_rise), .L_fall(l_fall)
`endif
  );
  chnl_smpl_packer #(.NUM_CH(3), .SYNC_STAGES(3), .SMPLS_PER_WORD(8)) dut5 (
    .clk(clk), .rst_n(rst_n), .smpl_en(en5), .clr(clr5), .CH_H(ch_h5), .CH_L(ch_l5),
    .smpl(smpl5), .smpl_vld(vld5), .smpl_rdy(rdy5), .ovfl(ovfl5), .ovfl_clr(oclr5)
`ifdef CHNL_EDGE_DET_EN
    , .H_rise(h_rise5), .H_fall(h_fall5), .L_rise(l_rise5), .L_fall(l_fall5)
`endif
  );
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic strobe(input logic h, input logic l);
    @(negedge clk);
    ch_h = h;
    ch_l = l;
    repeat (2) @(negedge clk);
    smpl_en = 1'b1;
    @(negedge clk);
    smpl_en = 1'b0;
  endtask
  task automatic word(input logic [3:0] h, input logic [3:0] l);
    for (int i = 0; i < 4; i++) strobe(h[i], l[i]);
  endtask
  task automatic strobe5(input logic [5:0] v, input int wait_n);
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      ch_h5[c] = v[2*c+1];
      ch_l5[c] = v[2*c];
    end
    repeat (wait_n) @(negedge clk);
    en5 = 1'b1;
    @(negedge clk);
    en5 = 1'b0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(negedge clk);
    check("rst_smpl", smpl, 0);
    check("rst_vld", smpl_vld, 0);
    check("rst_ovfl", ovfl, 0);
    check("rst_smpl5", smpl5, 0);
    rst_n = 1'b1;
`ifdef CHNL_EDGE_DET_EN
    strobe(1'b0, 1'b0);
    check("t6_s1_rise", h_rise, 0);
    strobe(1'b1, 1'b0);
    check("t6_s2_rise", h_rise, 1);
    check("t6_s2_fall", h_fall, 0);
    @(negedge clk);
    check("t6_gap_rise", h_rise, 0);
    strobe(1'b1, 1'b0);
    check("t6_s3_rise", h_rise, 0);
    strobe(1'b0, 1'b0);
    check("t6_s4_fall", h_fall, 1);
    check("t6_s4_rise", h_rise, 0);
    check("t6_s4_lrise", l_rise, 0);
    @(negedge clk);
    check("t6_gap_fall", h_fall, 0);
`endif
    word(4'b0101, 4'b0110);
    check("t1_smpl", smpl, 8'b00_11_01_10);
    check("t1_vld", smpl_vld, 1);
    check("t1_ovfl", ovfl, 0);
    @(negedge clk);
    check("t1_vld_drop", smpl_vld, 0);
    check("t1_smpl_keep", smpl, 8'b00_11_01_10);
    smpl_rdy = 1'b0;
    word(4'b0101, 4'b1001);
    check("t2_word_a", smpl, 8'b01_10_00_11);
    check("t2_vld_a", smpl_vld, 1);
    for (int i = 0; i < 4; i++) begin
      strobe(1'b0, 1'b0);
      check("t2_hold", smpl, 8'b01_10_00_11);
      check("t2_hold_vld", smpl_vld, 1);
    end
    check("t2_ovfl", ovfl, 1);
    ovfl_clr = 1'b1;
    @(negedge clk);
    ovfl_clr = 1'b0;
    check("t2_ovfl_clr", ovfl, 0);
    check("t2_vld_still", smpl_vld, 1);
    smpl_rdy = 1'b1;
    @(negedge clk);
    check("t2_accept_vld", smpl_vld, 0);
    check("t2_accept_smpl", smpl, 8'b01_10_00_11);
    smpl_rdy = 1'b0;
    word(4'b1111, 4'b0000);
    check("t3_word_c", smpl, 8'b10_10_10_10);
    for (int i = 0; i < 3; i++) strobe(1'b0, 1'b1);
    @(negedge clk);
    ch_h = 1'b0;
    ch_l = 1'b1;
    repeat (2) @(negedge clk);
    smpl_en = 1'b1;
    smpl_rdy = 1'b1;
    @(negedge clk);
    smpl_en = 1'b0;
    smpl_rdy = 1'b0;
    check("t3_word_d", smpl, 8'b01_01_01_01);
    check("t3_vld", smpl_vld, 1);
    check("t3_ovfl", ovfl, 0);
    smpl_rdy = 1'b1;
    strobe(1'b1, 1'b1);
    strobe(1'b1, 1'b1);
    @(negedge clk);
    repeat (2) @(negedge clk);
    smpl_en = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    smpl_en = 1'b0;
    clr = 1'b0;
    strobe(1'b0, 1'b1);
    strobe(1'b1, 1'b0);
    strobe(1'b0, 1'b0);
    check("t4_clr_no_early", smpl_vld, 0);
    strobe(1'b1, 1'b0);
    check("t4_clr_word", smpl, 8'b10_00_10_01);
    check("t4_clr_vld", smpl_vld, 1);
    strobe(1'b1, 1'b1);
    strobe(1'b1, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t4_rst_smpl", smpl, 0);
    check("t4_rst_vld", smpl_vld, 0);
    check("t4_rst_ovfl", ovfl, 0);
    @(negedge clk);
    rst_n = 1'b1;
    word(4'b0000, 4'b1111);
    check("t4_rst_word", smpl, 8'b01_01_01_01);
    check("t4_rst_vld1", smpl_vld, 1);
    for (int k = 0; k < 8; k++) strobe5(6'(1 << (k % 6)), 3);
    check("t5_walk", smpl5, 48'h0818_1020_4081);
    check("t5_vld", vld5, 1);
    strobe5(6'b111111, 2);
    for (int k = 0; k < 7; k++) strobe5(6'b000000, 3);
    check("t5_latency", smpl5, 48'h0000_0000_0002);
    check("t5_ovfl", ovfl5, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
